// File: rtl/fifo_flag_pkg.sv
// rtl/fifo_flag_pkg.sv - shared widths, types and depth helper for the FIFO flag controller
package fifo_flag_pkg;

  localparam int ADDR_W_DEF = 4;

  // Pointer and occupancy carry one extra bit so full and empty stay distinguishable
  typedef logic [ADDR_W_DEF:0] ptr_t;
  typedef logic [ADDR_W_DEF:0] cnt_t;

  function automatic int depth(input int addr_w);
    return 2 ** addr_w;
  endfunction

endpackage

// File: rtl/fifo_flag_ctrl_ptr.sv
// rtl/fifo_flag_ctrl_ptr.sv - fifo_ptr: wrap-bit pointer counter, one instance each for write and read
module fifo_ptr #(
  parameter int ADDR_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc,
  output logic [ADDR_W:0] ptr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_flag_ctrl.sv
// rtl/fifo_flag_ctrl.sv - FIFO pointer/flag controller with programmable almost thresholds
// Optional FIFO_FLAG_ERR_EN adds sticky overflow/underflow outputs.
module fifo_flag_ctrl
  import fifo_flag_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int AF_RST = 10,
  parameter int AE_RST = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_req,
  input  logic              rd_req,
  input  logic              thr_ld,
  input  logic [ADDR_W:0]   af_thr_in,
  input  logic [ADDR_W:0]   ae_thr_in,
  output logic              wr_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] w_ptr,
  output logic [ADDR_W-1:0] r_ptr,
  output logic [ADDR_W:0]   count,
`ifdef FIFO_FLAG_ERR_EN
  output logic              overflow,
  output logic              underflow,
`endif
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty
);

  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(depth(ADDR_W));
  localparam logic [ADDR_W:0] AF_RST_C = (ADDR_W+1)'(AF_RST);
  localparam logic [ADDR_W:0] AE_RST_C = (ADDR_W+1)'(AE_RST);

  logic [ADDR_W:0] wp;
  logic [ADDR_W:0] rp;
  logic [ADDR_W:0] count_nxt;
  logic [ADDR_W:0] af_thr;
  logic [ADDR_W:0] ae_thr;
  logic [ADDR_W:0] af_thr_nxt;
  logic [ADDR_W:0] ae_thr_nxt;

  function automatic logic [ADDR_W:0] sat_depth(input logic [ADDR_W:0] v);
    return (v > DEPTH_C) ? DEPTH_C : v;
  endfunction

  assign wr_en = wr_req & ~full;
  assign rd_en = rd_req & ~empty;

  fifo_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (wr_en),
    .ptr   (wp)
  );

  fifo_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (rd_en),
    .ptr   (rp)
  );

  assign w_ptr = wp[ADDR_W-1:0];
  assign r_ptr = rp[ADDR_W-1:0];
  assign count = wp - rp;

  // Flags look ahead to the post-edge occupancy and thresholds so they line up with count
  always_comb begin
    count_nxt  = count;
    af_thr_nxt = af_thr;
    ae_thr_nxt = ae_thr;
    if (wr_en && !rd_en) begin
      count_nxt = count + 1'b1;
    end else if (rd_en && !wr_en) begin
      count_nxt = count - 1'b1;
    end
    if (thr_ld) begin
      af_thr_nxt = sat_depth(af_thr_in);
      ae_thr_nxt = sat_depth(ae_thr_in);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      af_thr       <= AF_RST_C;
      ae_thr       <= AE_RST_C;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      af_thr       <= af_thr_nxt;
      ae_thr       <= ae_thr_nxt;
      full         <= (count_nxt == DEPTH_C);
      empty        <= (count_nxt == '0);
      almost_full  <= (count_nxt >= af_thr_nxt);
      almost_empty <= (count_nxt <= ae_thr_nxt);
    end
  end

`ifdef FIFO_FLAG_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= overflow | (wr_req & full);
      underflow <= underflow | (rd_req & empty);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_flag_ctrl.sv
// tb/tb_fifo_flag_ctrl.sv - self-checking bench for fifo_flag_ctrl against an occupancy model
module tb_fifo_flag_ctrl;

  localparam int D = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_req = 1'b0;
  logic       rd_req = 1'b0;
  logic       thr_ld = 1'b0;
  logic [4:0] af_thr_in = '0;
  logic [4:0] ae_thr_in = '0;
  logic       wr_en, rd_en, full, empty, almost_full, almost_empty;
  logic [3:0] w_ptr, r_ptr;
  logic [4:0] count;
`ifdef FIFO_FLAG_ERR_EN
  logic       overflow, underflow;
`endif

  int checks = 0;
  int failures = 0;

  fifo_flag_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_req       (wr_req),
    .rd_req       (rd_req),
    .thr_ld       (thr_ld),
    .af_thr_in    (af_thr_in),
    .ae_thr_in    (ae_thr_in),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .w_ptr        (w_ptr),
    .r_ptr        (r_ptr),
    .count        (count),
`ifdef FIFO_FLAG_ERR_EN
    .overflow     (overflow),
    .underflow    (underflow),
`endif
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  always #5 clk = ~clk;

  // Model: totals of accepted pushes/pops; occupancy is their difference
  int m_wr_tot = 0;
  int m_rd_tot = 0;
  int m_af = 10;
  int m_ae = 2;
  bit m_ovf = 0;
  bit m_unf = 0;

  function automatic int m_count();
    return m_wr_tot - m_rd_tot;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wr_tot <= 0;
      m_rd_tot <= 0;
      m_af     <= 10;
      m_ae     <= 2;
      m_ovf    <= 0;
      m_unf    <= 0;
    end else begin
      if (wr_req && m_count() < D) m_wr_tot <= m_wr_tot + 1;
      if (rd_req && m_count() > 0) m_rd_tot <= m_rd_tot + 1;
      if (thr_ld) begin
        m_af <= (int'(af_thr_in) > D) ? D : int'(af_thr_in);
        m_ae <= (int'(ae_thr_in) > D) ? D : int'(ae_thr_in);
      end
      if (wr_req && m_count() == D) m_ovf <= 1;
      if (rd_req && m_count() == 0) m_unf <= 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("wr_en", int'(wr_en), int'(wr_req && m_count() < D));
    chk("rd_en", int'(rd_en), int'(rd_req && m_count() > 0));
    chk("w_ptr", int'(w_ptr), m_wr_tot % D);
    chk("r_ptr", int'(r_ptr), m_rd_tot % D);
    chk("count", int'(count), m_count());
    chk("full", int'(full), int'(m_count() == D));
    chk("empty", int'(empty), int'(m_count() == 0));
    chk("almost_full", int'(almost_full), int'(rst_n && m_count() >= m_af));
    chk("almost_empty", int'(almost_empty), int'(m_count() <= m_ae));
`ifdef FIFO_FLAG_ERR_EN
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("underflow", int'(underflow), int'(m_unf));
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic r, input int n);
    wr_req = w;
    rd_req = r;
    for (int i = 0; i < n; i++) tick();
    wr_req = 1'b0;
    rd_req = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("lit_reset_count", int'(count), 0);
    chk("lit_reset_empty", int'(empty), 1);
    chk("lit_reset_ae", int'(almost_empty), 1);
    chk("lit_reset_af", int'(almost_full), 0);

    // Fill
    wr_req = 1'b1;
    for (int i = 1; i <= D; i++) begin
      tick();
      chk("lit_fill_count", int'(count), i);
      chk("lit_fill_af", int'(almost_full), int'(i >= 10));
      chk("lit_fill_full", int'(full), int'(i == 16));
    end
    chk("lit_17th_wr_en", int'(wr_en), 0);
    tick();
    wr_req = 1'b0;
    chk("lit_17th_count", int'(count), 16);
`ifdef FIFO_FLAG_ERR_EN
    chk("lit_overflow", int'(overflow), 1);
`endif

    // Drain
    rd_req = 1'b1;
    for (int i = 1; i <= D; i++) begin
      tick();
      chk("lit_drain_count", int'(count), 16 - i);
      chk("lit_drain_ae", int'(almost_empty), int'(16 - i <= 2));
      chk("lit_drain_empty", int'(empty), int'(i == 16));
    end
    chk("lit_extra_rd_en", int'(rd_en), 0);
    tick();
    rd_req = 1'b0;
    chk("lit_extra_rd_count", int'(count), 0);

    // Simultaneous at count 8: pointers wrap through 0xF
    drive(1'b1, 1'b0, 8);
    drive(1'b1, 1'b1, 20);
    chk("lit_simul_count", int'(count), 8);
    chk("lit_simul_w_ptr", int'(w_ptr), 12);
    chk("lit_simul_r_ptr", int'(r_ptr), 4);

    // Full with both requests
    drive(1'b1, 1'b0, 8);
    chk("lit_full_before", int'(full), 1);
    wr_req = 1'b1;
    rd_req = 1'b1;
    #1;
    chk("lit_fb_rd_en", int'(rd_en), 1);
    chk("lit_fb_wr_en", int'(wr_en), 0);
    tick();
    wr_req = 1'b0;
    rd_req = 1'b0;
    chk("lit_fb_count", int'(count), 15);
    chk("lit_fb_full", int'(full), 0);

    // Reset mid-burst, checked between clock edges
    wr_req = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    chk("lit_async_count", int'(count), 0);
    chk("lit_async_empty", int'(empty), 1);
    chk("lit_async_ae", int'(almost_empty), 1);
    chk("lit_async_full", int'(full), 0);
    chk("lit_async_w_ptr", int'(w_ptr), 0);
    chk("lit_async_r_ptr", int'(r_ptr), 0);
    wr_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Thresholds at count 5
    drive(1'b1, 1'b0, 5);
    chk("lit_thr_pre_af", int'(almost_full), 0);
    chk("lit_thr_pre_ae", int'(almost_empty), 0);
    thr_ld = 1'b1;
    af_thr_in = 5'd5;
    ae_thr_in = 5'd5;
    tick();
    chk("lit_thr5_af", int'(almost_full), 1);
    chk("lit_thr5_ae", int'(almost_empty), 1);
    af_thr_in = 5'd20;
    tick();
    chk("lit_thr20_af", int'(almost_full), 0);
    af_thr_in = 5'd0;
    ae_thr_in = 5'd16;
    tick();
    chk("lit_thr0_af", int'(almost_full), 1);
    chk("lit_thr16_ae", int'(almost_empty), 1);
    af_thr_in = 5'd16;
    ae_thr_in = 5'd0;
    tick();
    thr_ld = 1'b0;
    chk("lit_thr_ae0", int'(almost_empty), 0);
    chk("lit_thr_af16", int'(almost_full), 0);
    drive(1'b1, 1'b0, 11);
    chk("lit_thr_full16_af", int'(almost_full), 1);
    drive(1'b0, 1'b1, 16);
    chk("lit_thr_empty_ae0", int'(almost_empty), 1);
    drive(1'b0, 1'b1, 1);
`ifdef FIFO_FLAG_ERR_EN
    chk("lit_underflow", int'(underflow), 1);
`endif
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
